// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int ZERO_ADDR = 0;

    // Net change of the pending population for one edge: +1, -1 or 0.
    function automatic logic signed [1:0] popcount_inc(input logic set_new, input logic clr_old);
        logic signed [1:0] s;
        logic signed [1:0] c;
        s = signed'({1'b0, set_new});
        c = signed'({1'b0, clr_old});
        return s - c;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register "result pending" bits, their population count and read-port lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic                      mark_en,
    input  logic [$clog2(DEPTH)-1:0]  mark_addr,
    input  logic [$clog2(DEPTH)-1:0]  raddr_a,
    input  logic [$clog2(DEPTH)-1:0]  raddr_b,
    output logic                      pend_a,
    output logic                      pend_b,
    output logic [$clog2(DEPTH):0]    pend_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [AW:0]      count_q;
    logic             set_hit;
    logic             clr_hit;
    logic             set_new;
    logic             clr_old;
    logic signed [1:0]  delta;
    logic signed [AW:0] delta_ext;

    assign set_hit = mark_en && (mark_addr != ZA);
    assign clr_hit = we && (waddr != ZA);

    // Mark is applied after the clear so a same-address collision ends pending.
    always_comb begin
        pend_d = pend_q;
        if (clr_hit) pend_d[waddr] = 1'b0;
        if (set_hit) pend_d[mark_addr] = 1'b1;
    end

    assign set_new   = set_hit && !pend_q[mark_addr];
    assign clr_old   = clr_hit && pend_q[waddr] && !(set_hit && (mark_addr == waddr));
    assign delta     = popcount_inc(set_new, clr_old);
    assign delta_ext = (AW+1)'(delta);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_q + $unsigned(delta_ext);
        end
    end

    assign pend_count = count_q;

    always_comb begin
        pend_a = 1'b0;
        if (clr_n && (raddr_a != ZA)) begin
            if ((BYPASS != 0) && clr_hit && (waddr == raddr_a))
                pend_a = set_hit && (mark_addr == raddr_a);
            else
                pend_a = pend_q[raddr_a];
        end
    end

    always_comb begin
        pend_b = 1'b0;
        if (clr_n && (raddr_b != ZA)) begin
            if ((BYPASS != 0) && clr_hit && (waddr == raddr_b))
                pend_b = set_hit && (mark_addr == raddr_b);
            else
                pend_b = pend_q[raddr_b];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with hardwired-zero r0, optional write bypass and hazard scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]  raddr_a,
    input  logic [$clog2(DEPTH)-1:0]  raddr_b,
    output logic [WIDTH-1:0]          rdata_a,
    output logic [WIDTH-1:0]          rdata_b,
    input  logic                      mark_en,
    input  logic [$clog2(DEPTH)-1:0]  mark_addr,
    output logic                      pend_a,
    output logic                      pend_b,
    output logic                      hazard,
    output logic [$clog2(DEPTH):0]    pend_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             byp_a;
    logic             byp_b;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && (waddr != ZA)) begin
            mem[waddr] <= wdata;
        end
    end

    assign byp_a = (BYPASS != 0) && we && (waddr == raddr_a);
    assign byp_b = (BYPASS != 0) && we && (waddr == raddr_b);

    // r0 and reset both force zero, which also suppresses the bypass path.
    assign rdata_a = (!clr_n || (raddr_a == ZA)) ? '0 : (byp_a ? wdata : mem[raddr_a]);
    assign rdata_b = (!clr_n || (raddr_b == ZA)) ? '0 : (byp_b ? wdata : mem[raddr_b]);

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (clk),
        .clr_n      (clr_n),
        .we         (we),
        .waddr      (waddr),
        .mark_en    (mark_en),
        .mark_addr  (mark_addr),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .pend_a     (pend_a),
        .pend_b     (pend_b),
        .pend_count (pend_count)
    );

    assign hazard = pend_a | pend_b;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one BYPASS=0 and one BYPASS=1 instance share all inputs.
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic          mark_en;
    logic [AW-1:0] mark_addr;

    logic [W-1:0]  rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic          pend_a0, pend_b0, pend_a1, pend_b1;
    logic          hazard0, hazard1;
    logic [AW:0]   cnt0, cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) u_byp0 (
        .clk(clk), .clr_n(clr_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
        .mark_en(mark_en), .mark_addr(mark_addr), .pend_a(pend_a0), .pend_b(pend_b0),
        .hazard(hazard0), .pend_count(cnt0)
    );

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) u_byp1 (
        .clk(clk), .clr_n(clr_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
        .mark_en(mark_en), .mark_addr(mark_addr), .pend_a(pend_a1), .pend_b(pend_b1),
        .hazard(hazard1), .pend_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; mark_en = 1'b0; mark_addr = '0;
        repeat (2) tick();
        chk("rst_cnt", {cnt1, cnt0}, 0);
        chk("rst_haz", {hazard1, hazard0}, 0);
        clr_n = 1'b1;

        // Reset state on every address
        for (int i = 0; i < D; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(D - 1 - i);
            #1;
            chk("rst_rd", rdata_a0 | rdata_b0 | rdata_a1 | rdata_b1, 0);
            chk("rst_pend", {pend_a0, pend_b0, pend_a1, pend_b1}, 0);
        end
        chk("rst_cnt2", {cnt1, cnt0}, 0);

        // Write r5 while reading r5
        tick();
        raddr_a = 5; we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        #1;
        chk("wr_same_b0", rdata_a0, 32'h0);
        chk("wr_same_b1", rdata_a1, 32'hDEADBEEF);
        tick();
        we = 0;
        #1;
        chk("wr_next_b0", rdata_a0, 32'hDEADBEEF);
        chk("wr_next_b1", rdata_a1, 32'hDEADBEEF);

        // Zero register
        we = 1; waddr = 0; wdata = 32'h1234; mark_en = 1; mark_addr = 0; raddr_a = 0;
        #1;
        chk("r0_byp_rd", rdata_a1, 32'h0);
        chk("r0_byp_pend", pend_a1, 0);
        tick();
        we = 0; mark_en = 0;
        #1;
        chk("r0_rd", {rdata_a1, rdata_a0}, 0);
        chk("r0_pend", {pend_a1, pend_a0}, 0);
        chk("r0_cnt", {cnt1, cnt0}, 0);

        // Scoreboard: mark r3 then r7
        mark_en = 1; mark_addr = 3;
        tick();
        chk("mk3_cnt0", cnt0, 1);
        chk("mk3_cnt1", cnt1, 1);
        mark_addr = 7;
        tick();
        mark_en = 0;
        raddr_a = 3; raddr_b = 7;
        #1;
        chk("mk7_cnt0", cnt0, 2);
        chk("mk7_cnt1", cnt1, 2);
        chk("mk_pend_a", {pend_a1, pend_a0}, 2'b11);
        chk("mk_haz", {hazard1, hazard0}, 2'b11);

        // Write r3 clears its pending bit
        raddr_b = 0; we = 1; waddr = 3; wdata = 32'h33;
        #1;
        chk("clr_same_b0", pend_a0, 1);
        chk("clr_same_b1", pend_a1, 0);
        chk("clr_haz_b0", hazard0, 1);
        chk("clr_haz_b1", hazard1, 0);
        chk("clr_cnt_pre", {cnt1, cnt0}, {6'd2, 6'd2});
        tick();
        we = 0;
        #1;
        chk("clr_cnt", {cnt1, cnt0}, {6'd1, 6'd1});
        chk("clr_pend", {pend_a1, pend_a0}, 0);

        // Mark and write r9 together: mark wins, data still lands
        raddr_a = 9; we = 1; waddr = 9; wdata = 32'hAA; mark_en = 1; mark_addr = 9;
        #1;
        chk("mw_byp_rd", rdata_a1, 32'hAA);
        chk("mw_byp_pend", pend_a1, 1);
        chk("mw_b0_pend", pend_a0, 0);
        tick();
        we = 0; mark_en = 0;
        #1;
        chk("mw_rd", {rdata_a1, rdata_a0}, {32'hAA, 32'hAA});
        chk("mw_pend", {pend_a1, pend_a0}, 2'b11);
        chk("mw_cnt", {cnt1, cnt0}, {6'd2, 6'd2});

        // Re-mark r3, then mark r4 while clearing r3
        mark_en = 1; mark_addr = 3;
        tick();
        chk("rm3_cnt", {cnt1, cnt0}, {6'd3, 6'd3});
        mark_addr = 4; we = 1; waddr = 3; wdata = 32'h333;
        tick();
        we = 0; raddr_a = 4; raddr_b = 3;
        #1;
        chk("mc_cnt", {cnt1, cnt0}, {6'd3, 6'd3});
        chk("mc_pend_a", {pend_a1, pend_a0}, 2'b11);
        chk("mc_pend_b", {pend_b1, pend_b0}, 2'b00);
        // Marking an already-pending register leaves the count alone
        mark_addr = 7;
        tick();
        chk("dup_cnt", {cnt1, cnt0}, {6'd3, 6'd3});

        // Mark r2, r6, r8, then reset between edges
        mark_addr = 2;
        tick();
        mark_addr = 6;
        tick();
        mark_addr = 8;
        tick();
        mark_en = 0; raddr_a = 6; raddr_b = 9;
        #1;
        chk("pre_rst_cnt", {cnt1, cnt0}, {6'd6, 6'd6});
        chk("pre_rst_haz", {hazard1, hazard0}, 2'b11);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_cnt", {cnt1, cnt0}, 0);
        chk("mid_rst_haz", {hazard1, hazard0}, 0);
        chk("mid_rst_rd", rdata_b0 | rdata_b1, 0);
        clr_n = 1'b1;
        #1;
        chk("post_rst_rd", rdata_b0 | rdata_b1, 0);
        we = 1; waddr = 6; wdata = 32'h66;
        tick();
        we = 0;
        #1;
        chk("late_wr_cnt", {cnt1, cnt0}, 0);
        chk("late_wr_rd", {rdata_a1, rdata_a0}, {32'h66, 32'h66});
        chk("late_wr_haz", {hazard1, hazard0}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated pending-write scoreboard. It is the successor to the single-bit enable/clear flip-flop: it generalises storage to DEPTH words of WIDTH bits and adds optional write-to-read bypass plus per-register "result pending" tracking for multi-cycle units. It sits between decode, which reads operands and marks destinations of multi-cycle ops, and writeback, which writes results and clears pending bits. It also generates the operand-hazard stall.

## Interface
- WIDTH, 32, data word width (≥1)
- DEPTH, 32, number of registers (power of two, ≥2); AW = $clog2(DEPTH) is a derived localparam
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see committed state only
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr_a / raddr_b  in  AW  read addresses, ports A/B
- rdata_a / rdata_b  out  WIDTH  read data, combinational
- mark_en  in  1  set pending bit of mark_addr (multi-cycle op issued)
- mark_addr  in  AW  destination being marked
- pend_a / pend_b  out  1  read address currently pending
- hazard  out  1  pend_a | pend_b
- pend_count  out  AW+1  number of pending registers, registered

## Operation
- Register 0 is hardwired zero: writes to it are ignored, it is never pending, and reads of it return 0 regardless of BYPASS.
- Write: on a clk rising edge with we=1 and waddr≠0, reg[waddr]←wdata and pend[waddr]←0.
- Mark: on a clk rising edge with mark_en=1 and mark_addr≠0, pend[mark_addr]←1.
- Mark and write in the same cycle to the same address: mark wins. Data is written and the pending bit ends at 1; this is a new issue overwriting an old result.
- Mark and write to different addresses in the same cycle: both take effect.
- Marking an already-pending register keeps it at 1, and pend_count does not change.
- pend_count always equals popcount(pend[DEPTH-1:1]). It is updated each edge by +1, −1, or 0 from the net bit changes, and saturation is impossible by construction.
- Read, BYPASS=0: rdata_x = reg[raddr_x] and pend_x = pend[raddr_x].
- Read, BYPASS=1, when we=1 and waddr==raddr_x≠0:
  - rdata_x = wdata
  - pend_x = 0, unless mark_en=1 with mark_addr==raddr_x in the same cycle, in which case pend_x = 1
- Reset (clr_n=0, asynchronous): all reg words ←0, all pend bits ←0, pend_count ←0. While in reset, rdata_x=0, pend_x=0 and hazard=0; combinational bypass is suppressed.

## Timing
- Write-to-read latency is 1 cycle with BYPASS=0, and 0 cycles (same cycle) with BYPASS=1.
- A mark is visible on pend_x, hazard and pend_count the cycle after the mark edge.
- A clear is visible the cycle after the write edge, or in the same cycle on pend_x with BYPASS=1. pend_count always updates at the edge.
- Reset assertion takes effect immediately. Deassertion is synchronised externally; the first edge with clr_n=1 may write or mark.
- Reset asserted mid-operation discards all pending marks. Outstanding multi-cycle results arriving later are written normally, with no pending-bit side effects.
- There is no handshake. The caller stalls decode while hazard=1.

## Structure
- Package regfile_pkg holds:
  - defaults RF_WIDTH=32, RF_DEPTH=32
  - constant ZERO_ADDR='0
  - function popcount_inc(set_new, clr_old) returning the signed delta
- Sub-module regfile_scoreboard contains the pend bit vector, the mark/clear priority logic, pend_count and the pend_a/pend_b lookup including bypass override. Parameters are DEPTH and BYPASS.
- The top level owns the data array, the read muxes and the data bypass.

## Test plan
- Reset then read: hold clr_n=0, then release and read all addresses on A/B. Expect rdata=0, pend=0 and pend_count=0. Asserting clr_n=0 after writes clears everything without waiting for a clock.
- Write/read with BYPASS=0 and then BYPASS=1: write 0xDEADBEEF to r5 while reading r5. Expect 0 in the same cycle and 0xDEADBEEF the next cycle with BYPASS=0; expect 0xDEADBEEF in the same cycle with BYPASS=1.
- Zero register: write 0x1234 to r0 and mark r0. Expect rdata_a(r0)=0, pend_a=0 and pend_count=0.
- Scoreboard: mark r3, then mark r7.
  - Expect pend_count 1→2 and hazard=1 when reading r3.
  - Write r3: expect pend_count=1 and pend_a(r3)=0, same cycle with BYPASS=1 and next cycle with BYPASS=0.
- Simultaneous events:
  - Mark r9 and write r9=0xAA in the same cycle: expect rdata=0xAA, pend stays 1 and pend_count=+1.
  - Mark r4 and write pending r3 in the same cycle: expect the count unchanged.
- Reset mid-operation: mark r2, r6 and r8, then pulse clr_n low between edges. Expect pend_count=0 and hazard=0 immediately; a subsequent write to r6 leaves pend_count at 0.
